// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer
// Purpose  : Time-multiplexed FIR controller. Holds the sample delay line and
//            coefficient file, issues one tap per cycle to an external
//            registered multiplier, seeds/feeds back an external registered
//            accumulating adder, and presents the finished sum behind a
//            valid/ready handshake.
// Ports    : clk, rst (sync, active-low)
//            in_data/in_valid/in_ready       - sample input handshake
//            cfg_we/cfg_addr/cfg_data        - coefficient write port
//            mult_a/mult_b                   - multiplier operands
//            add_acc_in/add_acc_out          - accumulator feedback loop
//            out_data/out_valid/out_ready    - result output handshake
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer #(
    parameter int TAPS = 8,
    parameter int W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W-1:0]            in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    cfg_we,
    input  logic [$clog2(TAPS)-1:0] cfg_addr,
    input  logic [W-1:0]            cfg_data,
    output logic [W-1:0]            mult_a,
    output logic [W-1:0]            mult_b,
    output logic [W-1:0]            add_acc_in,
    input  logic [W-1:0]            add_acc_out,
    output logic [W-1:0]            out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int              c_AW   = $clog2(TAPS);
    localparam logic [c_AW-1:0] c_ONE  = c_AW'(1);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_buf  [TAPS];
    logic [W-1:0]    r_coef [TAPS];
    logic [c_AW-1:0] r_wp;
    logic [c_AW-1:0] r_k;
    logic            r_drain_2nd;
    logic [W-1:0]    r_mult_a;
    logic [W-1:0]    r_mult_b;
    logic            r_acc_pass;
    logic [W-1:0]    r_out_data;
    logic            r_out_valid;
    logic            r_in_ready;

    logic            w_accept;
    logic            w_cfg_wr;
    logic            w_capture;
    logic [W-1:0]    w_mult_a_nxt;
    logic [W-1:0]    w_mult_b_nxt;
    logic [c_AW-1:0] w_k_inc;
    logic [c_AW-1:0] w_rd_idx;

    // The operand registers are loaded one cycle ahead of the tap they carry,
    // so during MAC cycle k we fetch the operands of tap k+1. With wp already
    // advanced past the newest sample, tap k+1 lives at wp-2-k (mod TAPS);
    // the c_AW-bit arithmetic provides the modulo for free.
    assign w_k_inc  = r_k + c_ONE;
    assign w_rd_idx = r_wp - r_k - c_ONE - c_ONE;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_cfg_wr     = 1'b0;
        w_capture    = 1'b0;
        w_mult_a_nxt = '0;
        w_mult_b_nxt = '0;
        case (r_state)
            S_IDLE: begin
                w_cfg_wr = cfg_we;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_nxt  = S_MAC;
                    // Tap 0 is the sample arriving now; a same-cycle write to
                    // coef[0] is forwarded so this sample already uses it.
                    w_mult_a_nxt = in_data;
                    w_mult_b_nxt = (cfg_we && (cfg_addr == '0)) ? cfg_data : r_coef[0];
                end
            end
            S_MAC: begin
                if (r_k == c_LAST) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_mult_a_nxt = r_buf[w_rd_idx];
                    w_mult_b_nxt = r_coef[w_k_inc];
                end
            end
            S_DRAIN: begin
                // Two cycles cover the multiplier and adder latencies of the
                // final tap; the sum is on add_acc_out in the second one.
                if (r_drain_2nd) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_buf[i]  <= '0;
                r_coef[i] <= '0;
            end
            r_wp        <= '0;
            r_k         <= '0;
            r_drain_2nd <= 1'b0;
            r_mult_a    <= '0;
            r_mult_b    <= '0;
            r_acc_pass  <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            // cfg_addr spans exactly TAPS entries, so every index is in range.
            if (w_cfg_wr) begin
                r_coef[cfg_addr] <= cfg_data;
            end

            if (w_accept) begin
                r_buf[r_wp] <= in_data;
                r_wp        <= r_wp + c_ONE;
                r_k         <= '0;
            end else if (r_state == S_MAC) begin
                r_k <= w_k_inc;
            end

            if (r_state == S_DRAIN) begin
                r_drain_2nd <= !r_drain_2nd;
            end

            if (w_capture) begin
                r_out_data <= add_acc_out;
            end

            r_mult_a    <= w_mult_a_nxt;
            r_mult_b    <= w_mult_b_nxt;
            // The tap-0 product reaches the adder in MAC cycle k=1; the
            // accumulator is seeded with zero there and fed back otherwise.
            r_acc_pass  <= !((r_state == S_MAC) && (r_k == '0));
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign mult_a     = r_mult_a;
    assign mult_b     = r_mult_b;
    assign add_acc_in = r_acc_pass ? add_acc_out : '0;

endmodule
`default_nettype wire

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR controller that sequences one shared `multiplier` and one accumulating `adder` over `TAPS` coefficients per input sample. It holds the sample delay line and the coefficient file, issues one tap per cycle, and seeds and feeds back the accumulator. It captures the finished sum for the downstream `converter` stage behind a valid/ready output handshake.

## Interface
- `TAPS`, default 8: filter length; ≥2, power of two.
- `W`, default 16: sample, coefficient and accumulator width.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-low reset.
- `in_data` input W: new sample.
- `in_valid` input 1: sample offered.
- `in_ready` output 1: sample accepted on the cycle where `in_valid & in_ready`.
- `cfg_we` input 1: coefficient write strobe.
- `cfg_addr` input log2(TAPS): coefficient index.
- `cfg_data` input W: coefficient value.
- `mult_a` output W: sample operand to `multiplier.a`.
- `mult_b` output W: coefficient operand to `multiplier.b`.
- `add_acc_in` output W: accumulator operand to `adder.acc_in`.
- `add_acc_out` input W: from `adder.acc_out`.
- `out_data` output W: filter result.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes the result on `out_valid & out_ready`.

## Operation
- The top level wires `multiplier.result` directly to `adder.multiplier_out`. Both the multiplier and the adder are registered with 1-cycle latency.
- States: IDLE, MAC, DRAIN, DONE.
- IDLE:
  - `in_ready`=1.
  - On accept: `buf[wp] <= in_data`, `wp <= (wp+1) mod TAPS`, tap counter `k <= 0`, go to MAC.
- MAC: lasts TAPS cycles.
  - Cycle k drives `mult_a = buf[(wp_new-1-k) mod TAPS]` and `mult_b = coef[k]`.
  - Tap 0 is the newest sample.
  - After k = TAPS-1, go to DRAIN.
- DRAIN: lasts 2 cycles. At the end of the second cycle, `out_data <= add_acc_out`, then go to DONE.
- DONE:
  - `out_valid`=1; `out_data` is held.
  - On `out_ready`, go to IDLE.
- Operand gating: outside MAC, `mult_a`=`mult_b`=0.
- Accumulator seeding: `add_acc_in` = 0 on the cycle the tap-0 product is on `multiplier.result` (MAC cycle k=1, or the first DRAIN cycle when TAPS… never, since TAPS≥2). Otherwise `add_acc_in` = `add_acc_out`.
- Arithmetic: all sums wrap modulo 2^W. Product format is owned by `multiplier`; this block performs no scaling.
- Coefficient writes:
  - Honoured only in IDLE; ignored in any other state.
  - A write with `cfg_addr` ≥ TAPS is ignored.
  - A coefficient write and a sample accept in the same IDLE cycle both take effect, and the new coefficient is used for that sample.
- Reset (any state, including mid-MAC):
  - Next state IDLE.
  - `wp`=0, `k`=0.
  - All `buf` entries = 0 and all `coef` entries = 0.
  - `out_data`=0, `out_valid`=0, `in_ready`=1, `mult_a`=`mult_b`=`add_acc_in`=0.

## Timing
- Accept edge = cycle 0.
- MAC occupies cycles 1..TAPS.
- DRAIN occupies cycles TAPS+1 and TAPS+2.
- `out_valid` first high in cycle TAPS+3, so latency is TAPS+3 cycles.
- `in_ready` is low from cycle 1 until the cycle after the output handshake.
- Minimum sample period is TAPS+4 cycles (output accepted in the first DONE cycle).
- `out_data` and `out_valid` are stable while `out_valid & !out_ready`.
- All outputs are registered except `add_acc_in`, which is a registered select between 0 and `add_acc_out`.

## Test plan
Bench settings: TAPS=4, W=16, with real `multiplier`/`adder` or 1-cycle integer models (a*b, acc+p mod 2^16).
- Impulse: coefficients {1,2,3,4}; samples 1,0,0,0,0 -> `out_data` = 1,2,3,4,0.
- Step: same coefficients; samples 1,1,1,1,1 -> `out_data` = 1,3,6,10,10.
- Latency: accept at edge N -> `out_valid` rises in cycle N+7; `in_ready`=0 in cycles N+1..N+7; `in_valid` held high during that window is not accepted.
- Backpressure: `out_ready`=0 for 5 cycles in DONE -> `out_valid`=1 and `out_data` unchanged for all 5; `in_ready`=0 throughout; after `out_ready` pulses, `in_ready`=1 the next cycle.
- Config gating: writing `coef[0]`=9 during MAC -> ignored, impulse response still starts at 1. Writing `coef[0]`=9 in the same IDLE cycle as impulse accept -> first output is 9. A write to `cfg_addr`=4 is impossible at this width and needs no test.
- Reset mid-MAC: assert `rst` low for 1 cycle at cycle N+2 -> next cycle `out_valid`=0, `in_ready`=1, coefficients cleared; after reloading {1,2,3,4} and sending an impulse -> 1,2,3,4, with no residue from prior samples.
